// File: rtl/alu_pkg.sv
// Shared ALU op codes, exec FSM state type and op classification helpers.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } exec_state_t;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

  // Upper half of the code space is reserved.
  function automatic logic is_legal(input logic [ALU_OP_W-1:0] code);
    return code[ALU_OP_W-1] == 1'b0;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle op evaluator: ADD/SUB/AND/OR/XOR/SLT plus overflow and illegal flags.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    res_c,
  output logic                ovf_c,
  output logic                illegal_c
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  assign illegal_c = !is_legal(op);

  // Shift codes evaluate to zero here; the exec unit owns the shifter.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (op)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = diff;
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: res_c = a & b;
      ALU_OR:  res_c = a | b;
      ALU_XOR: res_c = a ^ b;
      ALU_SLT: res_c = WIDTH'(lt);
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution stage: single-cycle logic/arith, one-bit-per-cycle shifts,
// valid/ready handshakes on operand input and result output.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alucnt,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                ovf,
  output logic                illegal
);

  exec_state_t         state, state_d;
  logic [ALU_OP_W-1:0] op, op_d;
  logic [WIDTH-1:0]    shreg, shreg_d;
  logic [SHW-1:0]      cnt, cnt_d;
  logic [WIDTH-1:0]    result_d;
  logic                zero_d, ovf_d, illegal_d;
  logic                in_ready_d, out_valid_d;

  logic [WIDTH-1:0]    core_res;
  logic                core_ovf, core_illegal;
  logic [SHW-1:0]      amt;
  logic [WIDTH-1:0]    shifted;
  logic [WIDTH-1:0]    first_res;

  assign amt = b[SHW-1:0];

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op        (alucnt),
    .a         (a),
    .b         (b),
    .res_c     (core_res),
    .ovf_c     (core_ovf),
    .illegal_c (core_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= ALU_ADD;
      shreg     <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      op        <= op_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      result    <= result_d;
      zero      <= zero_d;
      ovf       <= ovf_d;
      illegal   <= illegal_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and datapath; handshake flags follow the next state so they stay registered.
  always_comb begin
    state_d   = state;
    op_d      = op;
    shreg_d   = shreg;
    cnt_d     = cnt;
    result_d  = result;
    zero_d    = zero;
    ovf_d     = ovf;
    illegal_d = illegal;
    shifted   = (op == ALU_SLL) ? (shreg << 1) : (shreg >> 1);
    first_res = is_shift(alucnt) ? a : core_res;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = alucnt;
          if (is_shift(alucnt) && (amt != '0)) begin
            shreg_d = a;
            cnt_d   = amt;
            state_d = ST_SHIFT;
          end else begin
            result_d  = first_res;
            zero_d    = (first_res == '0);
            ovf_d     = core_ovf;
            illegal_d = core_illegal;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          result_d  = shifted;
          zero_d    = (shifted == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alucnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alucnt    (alucnt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alucnt   = op;
    a        = av;
    b        = bv;
    step();
    in_valid = 1'b0;
    alucnt   = 4'b0000;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  // Issue, wait for the result, check it, then let out_ready=1 consume it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eres, input logic ez,
                        input logic eo, input logic ei, input int elat);
    int lat;
    issue(op, av, bv);
    wait_valid(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
    check_eq({tag, "_result"}, result, eres);
    check_eq({tag, "_zero"}, 32'(zero), 32'(ez));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check_eq({tag, "_illegal"}, 32'(illegal), 32'(ei));
    step();
    check_eq({tag, "_consumed"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Outputs must not move while a result waits under back-pressure.
  logic             hold_q = 1'b0;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;
  always @(negedge clk) begin
    if (hold_q) begin
      check_eq("hold_result", result, res_q);
      check_eq("hold_flags", 32'({zero, ovf, illegal, out_valid}), 32'(flg_q));
    end
    hold_q <= out_valid && !out_ready && !rst;
    res_q  <= result;
    flg_q  <= {zero, ovf, illegal, out_valid};
  end

  initial begin
    int lat;
    int stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alucnt    = 4'b0000;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    step();
    step();
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_result", result, 32'd0);
    check_eq("reset_flags", 32'({zero, ovf, illegal}), 32'd0);
    rst = 1'b0;
    step();
    check_eq("post_reset_in_ready", 32'(in_ready), 32'd1);

    run_op("add_ovf",   ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
    run_op("sub_zero",  ALU_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
    run_op("sub_ovf",   ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    run_op("slt_true",  ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    run_op("slt_false", ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
    run_op("and",       ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 0);
    run_op("or",        ALU_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0, 1'b0, 0);
    run_op("add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
    run_op("sll31",     ALU_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 31);
    run_op("srl4",      ALU_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 1'b0, 4);
    run_op("sll0",      ALU_SLL, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 1'b0, 0);
    run_op("srl_lowb",  ALU_SRL, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 1'b0, 1'b0, 1'b0, 4);
    run_op("sll_out",   ALU_SLL, 32'h8000_0000, 32'd1,         32'h0000_0000, 1'b1, 1'b0, 1'b0, 1);
    run_op("illegal",   4'b1010, 32'd5,         32'd3,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
    run_op("add_after", ALU_ADD, 32'd2,         32'd3,         32'h0000_0005, 1'b0, 1'b0, 1'b0, 0);

    // Back-pressure: result held for 10 cycles, then released.
    out_ready = 1'b0;
    issue(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    wait_valid(lat);
    check_eq("bp_latency", 32'(lat), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_result", result, 32'hF00F_F00F);
      check_eq("bp_valid_ready", 32'({out_valid, in_ready}), 32'b10);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_release", 32'({out_valid, in_ready}), 32'b01);

    // Reset on the 3rd cycle of an SLL by 20 discards it.
    issue(ALU_SLL, 32'h0000_0001, 32'd20);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_shift_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_shift_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_shift_result", result, 32'd0);
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) stale++;
    end
    check_eq("rst_shift_no_stale", 32'(stale), 32'd0);

    // Reset while a result is held in DONE.
    out_ready = 1'b0;
    issue(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    wait_valid(lat);
    check_eq("rst_done_pre_result", result, 32'h0000_00FF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_eq("rst_done_state", 32'({out_valid, in_ready}), 32'b01);
    check_eq("rst_done_result", result, 32'd0);

    run_op("final_add", ALU_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
